product_accumulator: RTL
========================

// Module: product_accumulator
// PURPOSE
//  Collecting end of the nibble-select datapath of the 8x8 sequential multiplier.
//  The mux steers 4-bit operand nibbles into the 4x4 multiplier; this block receives
//  the resulting 8-bit partial products, shifts each by its nibble weight and
//  accumulates them into the 16-bit product. After four accepted beats it presents
//  the final product with a done flag, ready for the seven-segment/output stage.
// PARAMETERS
//  NIB_W   4          nibble width; partial product = 2*NIB_W, product = 4*NIB_W
//  N_BEATS 4          partial products per multiplication
// PORTS
//  clk        in   1          rising-edge clock, sole clock
//  reset_a    in   1          synchronous, active-high reset
//  start      in   1          1-cycle pulse: clear accumulator, begin new product
//  pp_valid   in   1          pp_in/pp_shift valid this cycle
//  pp_in      in   2*NIB_W    partial product from 4x4 multiplier
//  pp_shift   in   2          nibble weight: shift left by NIB_W*pp_shift bits
//  pp_ready   out  1          block accepts a beat this cycle
//  product    out  4*NIB_W    accumulated product
//  busy       out  1          accumulation in progress
//  done       out  1          product final and stable
//  ovf        out  1          sticky carry-out flag (only with PROD_ACC_OVF_EN)
// BEHAVIOUR
//  - Reset (reset_a=1 at clk edge): state=IDLE, product=0, beat count=0, busy=0,
//    done=0, pp_ready=0, ovf=0. Reset wins over start and any beat in that cycle;
//    a reset mid-accumulation discards the partial result.
//  - FSM states IDLE, ACC, DONE:
//    IDLE: pp_ready=0; start -> ACC (product<=0, count<=0).
//    ACC : pp_ready=1, busy=1. Beat accepted iff pp_valid&&pp_ready:
//          product <= product + ({pp_in,zeros} aligned: pp_in << NIB_W*pp_shift),
//          sum truncated to 4*NIB_W bits; count<=count+1. On the N_BEATS-th
//          accepted beat -> DONE. Cycles with pp_valid=0 leave state unchanged.
//    DONE: done=1, busy=0, pp_ready=0; product held; pp_valid ignored.
//          start -> ACC (clear, count=0, done drops next cycle).
//  - start in ACC restarts: product<=0, count<=0; a beat presented in the same
//    cycle is NOT accumulated (start has priority).
//  - Latency: product reflects an accepted beat one clock after acceptance; done
//    rises on the clock edge that accepts the final beat (visible next cycle).
//  - pp_shift=3 is legal: shift by 3*NIB_W, bits above 4*NIB_W-1 dropped.
//  - Beat order is free; addition is commutative, final product order-independent.
//  - Outputs registered except pp_ready/busy/done, decoded from state register.
// CONFIGURATION
//  PROD_ACC_OVF_EN defined: port ovf present; set to 1 on any accepted beat whose
//   add produces carry out of bit 4*NIB_W-1 or whose shifted pp_in loses bits;
//   sticky until start or reset. Never set for valid 8x8 multiplication.
//  Not defined: ovf port absent; overflowed sums wrap silently mod 2^(4*NIB_W).
// TESTING
//  1 Reset: assert reset_a 2 cycles -> product=0x0000, done=0, busy=0, pp_ready=0.
//  2 0xAB*0xCD: start; beats (0x8F,0),(0x82,1),(0x84,1),(0x78,2) -> product=0x88EF,
//    done=1 the cycle after 4th beat, pp_ready=0 in DONE.
//  3 0xFF*0xFF with pp_valid gaps: beats (0xE1,0),idle,(0xE1,1),(0xE1,1),idle,(0xE1,2)
//    -> product=0xFE01 after 4th accepted beat; gaps do not advance count.
//  4 Restart: start, 2 beats of 2, then start with pp_valid=1 same cycle, then
//    (0x06,0)x4 -> product=0x0018; colliding beat not accumulated.
//  5 Reset mid-op: start, 3 beats, reset_a=1 -> IDLE, product=0; pp_valid while
//    IDLE ignored; product stays 0x0000.
//  6 PROD_ACC_OVF_EN: start, (0xFF,3),(0xFF,3) -> ovf=1 (0xF0 lost bits), product
//    =0xE000; start clears ovf=0. Without macro: same product, no ovf port.

Source files
------------

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - shifts and sums 4x4 partial products into the 8x8 product
// Optional sticky carry-out flag on port ovf is built when PROD_ACC_OVF_EN is defined.
module product_accumulator #(
  parameter int NIB_W   = 4,
  parameter int N_BEATS = 4
) (
  input  logic               clk,
  input  logic               reset_a,
  input  logic               start,
  input  logic               pp_valid,
  input  logic [2*NIB_W-1:0] pp_in,
  input  logic [1:0]         pp_shift,
  output logic               pp_ready,
  output logic [4*NIB_W-1:0] product,
  output logic               busy,
`ifdef PROD_ACC_OVF_EN
  output logic               ovf,
`endif
  output logic               done
);

  localparam int PROD_W = 4 * NIB_W;
  localparam int EXT_W  = 5 * NIB_W;
  localparam int CNT_W  = $clog2(N_BEATS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PROD_W-1:0]   product_q, product_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [EXT_W-1:0]    shifted;
  logic [PROD_W:0]     sum;
  logic                wrap;

  // Widened so bits pushed past the product by pp_shift=3 stay observable.
  always_comb begin
    shifted = {{(EXT_W - 2*NIB_W){1'b0}}, pp_in} << (NIB_W * int'(pp_shift));
    sum     = {1'b0, product_q} + {1'b0, shifted[PROD_W-1:0]};
    wrap    = sum[PROD_W] | (|shifted[EXT_W-1:PROD_W]);
  end

`ifdef PROD_ACC_OVF_EN
  logic ovf_q, ovf_d;
`else
  logic unused_wrap;
  assign unused_wrap = wrap;
`endif

  always_comb begin
    state_d   = state_q;
    product_d = product_q;
    count_d   = count_q;
`ifdef PROD_ACC_OVF_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = ACC;
          product_d = '0;
          count_d   = '0;
`ifdef PROD_ACC_OVF_EN
          ovf_d     = 1'b0;
`endif
        end
      end
      ACC: begin
        // start wins over a beat presented in the same cycle
        if (start) begin
          product_d = '0;
          count_d   = '0;
`ifdef PROD_ACC_OVF_EN
          ovf_d     = 1'b0;
`endif
        end else if (pp_valid) begin
          product_d = sum[PROD_W-1:0];
          count_d   = count_q + 1'b1;
`ifdef PROD_ACC_OVF_EN
          ovf_d     = ovf_q | wrap;
`endif
          if (count_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_a) begin
      state_q   <= IDLE;
      product_q <= '0;
      count_q   <= '0;
`ifdef PROD_ACC_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      product_q <= product_d;
      count_q   <= count_d;
`ifdef PROD_ACC_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign product  = product_q;
  assign pp_ready = (state_q == ACC);
  assign busy     = (state_q == ACC);
  assign done     = (state_q == DONE);
`ifdef PROD_ACC_OVF_EN
  assign ovf      = ovf_q;
`endif

endmodule
